// File: rtl/spi_pkg.sv
// Shared definitions for the SPI datapath: state encoding, default sizes and
// the frame-length / frame-count saturation rules.
package spi_pkg;

  localparam int MAX_BITS_DEF = 32;
  localparam int CNT_W_DEF    = 6;
  localparam int FRM_W_DEF    = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // A zero or oversized length means "longest frame supported".
  function automatic logic [31:0] eff_len(input logic [31:0] len,
                                          input logic [31:0] max_bits);
    return (len == 32'd0 || len > max_bits) ? max_bits : len;
  endfunction

  function automatic logic [31:0] eff_frames(input logic [31:0] frames);
    return (frames == 32'd0) ? 32'd1 : frames;
  endfunction

endpackage

// File: rtl/spi_len_sat.sv
// Combinational saturation of the requested frame length and frame count to
// the values the counter and the shift register actually use.
module spi_len_sat
  import spi_pkg::*;
#(
  parameter int MAX_BITS = MAX_BITS_DEF,
  parameter int CNT_W    = CNT_W_DEF,
  parameter int FRM_W    = FRM_W_DEF
) (
  input  logic [CNT_W-1:0] frame_len,
  input  logic [FRM_W-1:0] frames,
  output logic [CNT_W-1:0] len_eff,
  output logic [FRM_W-1:0] frm_eff
);

  assign len_eff = CNT_W'(eff_len(32'(frame_len), 32'(MAX_BITS)));
  assign frm_eff = FRM_W'(eff_frames(32'(frames)));

endmodule

// File: rtl/spi_frame_counter.sv
// Bit/frame counter for SPI bursts: counts sampling edges into frames and
// frames into a burst, and produces the shift-register bit select.
module spi_frame_counter
  import spi_pkg::*;
#(
  parameter int MAX_BITS = MAX_BITS_DEF,
  parameter int CNT_W    = CNT_W_DEF,
  parameter int FRM_W    = FRM_W_DEF
) (
  input  logic             counter_s_clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic             lsb_first,
  input  logic [CNT_W-1:0] frame_len,
  input  logic [FRM_W-1:0] frames,
  output logic [CNT_W-1:0] bit_cnt,
  output logic [CNT_W-1:0] bit_idx,
  output logic [FRM_W-1:0] frame_idx,
  output logic             frame_done,
  output logic             burst_done,
  output logic             busy
);

  state_t           state, state_n;
  logic [CNT_W-1:0] len_q, len_n, len_eff, use_len, prior, nxt, idx_len, bit_cnt_n;
  logic [FRM_W-1:0] frm_q, frm_n, frm_eff, use_frm, frame_idx_n;
  logic             frame_done_n, burst_done_n, count;

  spi_len_sat #(.MAX_BITS(MAX_BITS), .CNT_W(CNT_W), .FRM_W(FRM_W)) u_len_sat (
    .frame_len(frame_len),
    .frames   (frames),
    .len_eff  (len_eff),
    .frm_eff  (frm_eff)
  );

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of the others, regardless of statement order.
  always_ff @(posedge counter_s_clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      frame_idx  <= '0;
      frame_done <= 1'b0;
      burst_done <= 1'b0;
      len_q      <= CNT_W'(MAX_BITS);
      frm_q      <= FRM_W'(1);
    end else begin
      state      <= state_n;
      bit_cnt    <= bit_cnt_n;
      frame_idx  <= frame_idx_n;
      frame_done <= frame_done_n;
      burst_done <= burst_done_n;
      len_q      <= len_n;
      frm_q      <= frm_n;
    end
  end

  // NOTE: every signal gets a default before any branch so this block can
  // never infer a latch.
  always_comb begin
    state_n      = state;
    bit_cnt_n    = bit_cnt;
    frame_idx_n  = frame_idx;
    frame_done_n = 1'b0;
    burst_done_n = burst_done;
    len_n        = len_q;
    frm_n        = frm_q;
    use_len      = len_q;
    use_frm      = frm_q;
    prior        = bit_cnt;
    nxt          = '0;
    count        = 1'b0;

    if (clr) begin
      state_n      = IDLE;
      bit_cnt_n    = '0;
      frame_idx_n  = '0;
      burst_done_n = 1'b0;
      len_n        = CNT_W'(MAX_BITS);
      frm_n        = FRM_W'(1);
    end else begin
      unique case (state)
        IDLE: begin
          // The burst geometry is captured here once and frozen until clr.
          if (en) begin
            count   = 1'b1;
            prior   = '0;
            use_len = len_eff;
            use_frm = frm_eff;
            len_n   = len_eff;
            frm_n   = frm_eff;
            state_n = SHIFT;
          end
        end
        SHIFT:   count = en;
        DONE:    ;
        default: state_n = IDLE;
      endcase

      if (count) begin
        nxt = prior + CNT_W'(1);
        if (nxt < use_len) begin
          bit_cnt_n = nxt;
        end else begin
          bit_cnt_n    = '0;
          frame_done_n = 1'b1;
          frame_idx_n  = frame_idx + FRM_W'(1);
          if (frame_idx_n == use_frm) begin
            state_n      = DONE;
            burst_done_n = 1'b1;
          end
        end
      end
    end
  end

  assign idx_len = (state == IDLE) ? len_eff : len_q;
  assign bit_idx = lsb_first ? bit_cnt : (idx_len - CNT_W'(1) - bit_cnt);
  assign busy    = (state == SHIFT);

endmodule

// File: tb/tb_spi_frame_counter.sv
// Randomized and directed bench for spi_frame_counter with a queue-based
// scoreboard fed by a burst-position reference model.
module tb_spi_frame_counter;

  localparam int MAX_BITS = 32;
  localparam int CNT_W    = 6;
  localparam int FRM_W    = 8;

  typedef struct {
    int bit_cnt;
    int bit_idx;
    int frame_idx;
    int frame_done;
    int burst_done;
    int busy;
  } exp_t;

  logic             counter_s_clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             clr = 1'b0;
  logic             en = 1'b0;
  logic             lsb_first = 1'b0;
  logic [CNT_W-1:0] frame_len = '0;
  logic [FRM_W-1:0] frames = '0;
  logic [CNT_W-1:0] bit_cnt, bit_idx;
  logic [FRM_W-1:0] frame_idx;
  logic             frame_done, burst_done, busy;

  int   errors = 0;
  int   checks = 0;
  exp_t sb_q[$];

  // Reference model: a burst is just "k bits counted out of L*F".
  bit m_started = 0;
  int m_k = 0, m_len = MAX_BITS, m_frm = 1, m_fd = 0;

  spi_frame_counter #(.MAX_BITS(MAX_BITS), .CNT_W(CNT_W), .FRM_W(FRM_W)) dut (
    .counter_s_clk(counter_s_clk),
    .rst_n        (rst_n),
    .clr          (clr),
    .en           (en),
    .lsb_first    (lsb_first),
    .frame_len    (frame_len),
    .frames       (frames),
    .bit_cnt      (bit_cnt),
    .bit_idx      (bit_idx),
    .frame_idx    (frame_idx),
    .frame_done   (frame_done),
    .burst_done   (burst_done),
    .busy         (busy)
  );

  always #5 counter_s_clk = ~counter_s_clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int eff_len_m(input int l);
    return (l == 0 || l > MAX_BITS) ? MAX_BITS : l;
  endfunction

  function automatic exp_t expect_now();
    exp_t e;
    if (!m_started) begin
      e.bit_cnt = 0; e.frame_idx = 0; e.burst_done = 0; e.busy = 0;
      e.bit_idx = lsb_first ? 0 : eff_len_m(int'(frame_len)) - 1;
    end else begin
      e.bit_cnt    = m_k % m_len;
      e.frame_idx  = m_k / m_len;
      e.burst_done = (m_k == m_len * m_frm) ? 1 : 0;
      e.busy       = 1 - e.burst_done;
      e.bit_idx    = lsb_first ? e.bit_cnt : m_len - 1 - e.bit_cnt;
    end
    e.frame_done = m_fd;
    return e;
  endfunction

  task automatic model_edge();
    m_fd = 0;
    if (clr) begin
      m_started = 0;
      m_k = 0;
    end else if (!m_started) begin
      if (en) begin
        m_started = 1;
        m_len = eff_len_m(int'(frame_len));
        m_frm = (frames == 0) ? 1 : int'(frames);
        m_k = 1;
        m_fd = (m_k % m_len == 0) ? 1 : 0;
      end
    end else if (m_k < m_len * m_frm) begin
      if (en) begin
        m_k++;
        m_fd = (m_k % m_len == 0) ? 1 : 0;
      end
    end
  endtask

  // One sampling edge: inputs are held from here until after the monitor's
  // negedge sample, then released for the next step.
  task automatic step(input bit c, input bit e, input bit lsb,
                      input int fl, input int fr);
    clr = c; en = e; lsb_first = lsb;
    frame_len = CNT_W'(fl); frames = FRM_W'(fr);
    @(posedge counter_s_clk);
    model_edge();
    sb_q.push_back(expect_now());
    @(negedge counter_s_clk);
    #1;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge counter_s_clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check("bit_cnt",    int'(bit_cnt),    e.bit_cnt);
        check("bit_idx",    int'(bit_idx),    e.bit_idx);
        check("frame_idx",  int'(frame_idx),  e.frame_idx);
        check("frame_done", int'(frame_done), e.frame_done);
        check("burst_done", int'(burst_done), e.burst_done);
        check("busy",       int'(busy),       e.busy);
      end
    end
  end

  task automatic clear_burst();
    step(1, 0, 0, 8, 1);
  endtask

  initial begin : driver
    @(negedge counter_s_clk);
    #1;
    rst_n = 1'b1;
    check("reset_bit_cnt",   int'(bit_cnt),    0);
    check("reset_frame_idx", int'(frame_idx),  0);
    check("reset_busy",      int'(busy),       0);
    check("reset_burst",     int'(burst_done), 0);

    // Asynchronous reset in the middle of a burst.
    for (int i = 0; i < 5; i++) step(0, 1, 0, 8, 2);
    rst_n = 1'b0;
    #1;
    check("async_rst_bit_cnt",    int'(bit_cnt),    0);
    check("async_rst_frame_idx",  int'(frame_idx),  0);
    check("async_rst_frame_done", int'(frame_done), 0);
    check("async_rst_burst_done", int'(burst_done), 0);
    check("async_rst_busy",       int'(busy),       0);
    m_started = 0; m_k = 0; m_fd = 0;
    @(negedge counter_s_clk);
    #1;
    rst_n = 1'b1;

    // Single 8-bit frame MSB-first, then extra edges in DONE.
    for (int i = 0; i < 12; i++) step(0, 1, 0, 8, 1);
    clear_burst();

    // Three 4-bit frames LSB-first.
    for (int i = 0; i < 14; i++) step(0, 1, 1, 4, 3);
    clear_burst();

    // Pause in the middle of a frame.
    for (int i = 0; i < 3; i++) step(0, 1, 0, 8, 1);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 8, 1);
    for (int i = 0; i < 6; i++) step(0, 1, 0, 8, 1);
    clear_burst();

    // Zero length/frames saturate; later frame_len changes are ignored.
    step(0, 1, 1, 0, 0);
    for (int i = 0; i < 33; i++) step(0, 1, 1, 4, 0);
    clear_burst();

    // Single-bit single-frame burst finishes on its first edge.
    step(0, 1, 0, 1, 1);
    step(0, 1, 0, 1, 1);
    clear_burst();

    // clr wins over the completing edge, then counting restarts.
    for (int i = 0; i < 3; i++) step(0, 1, 0, 4, 1);
    step(1, 1, 0, 4, 1);
    step(0, 1, 0, 4, 1);
    clear_burst();

    // Randomized bursts with mid-burst input noise and occasional clr.
    for (int i = 0; i < 3000; i++) begin
      int fl, fr;
      case ($urandom_range(0, 9))
        0:       fl = 0;
        1:       fl = $urandom_range(33, 63);
        2:       fl = $urandom_range(7, 32);
        default: fl = $urandom_range(1, 6);
      endcase
      fr = $urandom_range(0, 4);
      step(($urandom_range(0, 59) == 0), ($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 1)), fl, fr);
    end

    @(negedge counter_s_clk);
    #1;
    check("scoreboard_drained", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
